// File: rtl/clk_delay_ctrl.sv
// Glitch-safe tap sequencer and sweep calibrator for configurable_delay: gate, retap, settle, ungate.
// Manual apply takes GATE_CYCLES+SETTLE_CYCLES cycles; cfg_ready_o is low whenever the controller is busy.
module clk_delay_ctrl #(
    parameter int NUM_STEPS     = 8,
    parameter int DEFAULT_DELAY = 0,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    localparam int DelW = $clog2(NUM_STEPS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [DelW-1:0] cfg_delay_i,
    input  logic            sweep_start_i,
    output logic            eval_req_o,
    input  logic            eval_done_i,
    input  logic            eval_pass_i,
    output logic [DelW-1:0] delay_o,
    output logic            enable_o,
    output logic            busy_o,
    output logic            cal_done_o,
    output logic            cal_ok_o,
    output logic [DelW-1:0] win_lo_o,
    output logic [DelW-1:0] win_hi_o
);

    localparam int MaxCyc = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CntW   = $clog2(MaxCyc + 1);
    localparam logic [CntW-1:0] GateLast   = CntW'(GATE_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 2);
    localparam logic [DelW-1:0] LastTap    = DelW'(NUM_STEPS - 1);
    localparam logic [DelW-1:0] DefTap     = DelW'(DEFAULT_DELAY);

    typedef enum logic [2:0] {IDLE, GATE, UPDATE, SETTLE, EVAL, DONE} state_t;

    state_t          state, state_nxt;
    logic [CntW-1:0] cnt;
    logic [DelW-1:0] tgt, idx, pre, lo, hi;
    logic [DelW:0]   mid_sum;
    logic            sweeping, cal_pend, win_open, win_closed, win_found;
    logic            start_sweep, cfg_fire, eval_fire, gate_end, settle_end;

    assign start_sweep = (state == IDLE) && sweep_start_i;
    assign cfg_fire    = (state == IDLE) && !sweep_start_i && cfg_valid_i;
    assign eval_fire   = (state == EVAL) && eval_done_i;
    assign gate_end    = (state == GATE) && (cnt == GateLast);
    // With a single settle cycle the UPDATE cycle itself is the whole settle time.
    assign settle_end  = (SETTLE_CYCLES == 1) ? (state == UPDATE)
                                              : ((state == SETTLE) && (cnt == SettleLast));
    assign win_found   = win_open || win_closed;
    assign mid_sum     = {1'b0, lo} + {1'b0, hi};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sweep || cfg_fire) state_nxt = GATE;
            GATE:    if (gate_end) state_nxt = UPDATE;
            UPDATE:  state_nxt = settle_end ? (sweeping ? EVAL : IDLE) : SETTLE;
            SETTLE:  if (settle_end) state_nxt = sweeping ? EVAL : IDLE;
            EVAL:    if (eval_done_i) state_nxt = (idx == LastTap) ? DONE : GATE;
            DONE:    state_nxt = GATE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        enable_o    = (state == IDLE) || (state == EVAL) || (state == DONE);
        eval_req_o  = (state == EVAL);
        busy_o      = (state != IDLE);
        cfg_ready_o = (state == IDLE) && !sweep_start_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if ((state == GATE) || (state == SETTLE)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_o    <= DefTap;
            tgt        <= DefTap;
            pre        <= DefTap;
            idx        <= '0;
            lo         <= '0;
            hi         <= '0;
            win_open   <= 1'b0;
            win_closed <= 1'b0;
            sweeping   <= 1'b0;
            cal_pend   <= 1'b0;
            cal_done_o <= 1'b0;
            cal_ok_o   <= 1'b0;
            win_lo_o   <= '0;
            win_hi_o   <= '0;
        end else begin
            cal_done_o <= 1'b0;
            if (start_sweep) begin
                sweeping   <= 1'b1;
                pre        <= delay_o;
                idx        <= '0;
                tgt        <= '0;
                lo         <= '0;
                hi         <= '0;
                win_open   <= 1'b0;
                win_closed <= 1'b0;
            end else if (cfg_fire) begin
                tgt <= cfg_delay_i;
            end
            // Only retap on the GATE->UPDATE edge, when the delayed clock is already gated.
            if (gate_end) delay_o <= tgt;
            if (eval_fire) begin
                if (eval_pass_i && !win_open && !win_closed) begin
                    lo       <= idx;
                    hi       <= idx;
                    win_open <= 1'b1;
                end else if (eval_pass_i && win_open) begin
                    hi <= idx;
                end else if (!eval_pass_i && win_open) begin
                    win_open   <= 1'b0;
                    win_closed <= 1'b1;
                end
                if (idx != LastTap) begin
                    idx <= idx + 1'b1;
                    tgt <= idx + 1'b1;
                end
            end
            if (state == DONE) begin
                sweeping <= 1'b0;
                cal_pend <= 1'b1;
                tgt      <= win_found ? mid_sum[DelW:1] : pre;
            end
            if (settle_end && !sweeping && cal_pend) begin
                cal_pend   <= 1'b0;
                cal_done_o <= 1'b1;
                cal_ok_o   <= win_found;
                win_lo_o   <= win_found ? lo : '0;
                win_hi_o   <= win_found ? hi : '0;
            end
        end
    end

endmodule

// File: tb/tb_clk_delay_ctrl.sv
// Bench for clk_delay_ctrl: table-driven manual/sweep vectors, scoreboard of results, corner sequences.
module tb_clk_delay_ctrl;
    localparam int N = 8;
    localparam int G = 2;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0, cfg_ready;
    logic [2:0] cfg_delay = '0;
    logic       sweep_start = 1'b0;
    logic       eval_req, eval_done = 1'b0, eval_pass = 1'b0;
    logic [2:0] delay, win_lo, win_hi;
    logic       enable, busy, cal_done, cal_ok;

    always #5 clk = ~clk;

    clk_delay_ctrl #(
        .NUM_STEPS(N), .DEFAULT_DELAY(0), .GATE_CYCLES(G), .SETTLE_CYCLES(S)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_delay_i(cfg_delay),
        .sweep_start_i(sweep_start),
        .eval_req_o(eval_req), .eval_done_i(eval_done), .eval_pass_i(eval_pass),
        .delay_o(delay), .enable_o(enable), .busy_o(busy),
        .cal_done_o(cal_done), .cal_ok_o(cal_ok), .win_lo_o(win_lo), .win_hi_o(win_hi)
    );

    typedef struct { logic [2:0] req; logic [2:0] exp_dly; } man_vec_t;
    typedef struct {
        logic [7:0] mask; logic [2:0] pre; bit spurious;
        bit ok; logic [2:0] lo; logic [2:0] hi; logic [2:0] dly;
    } sw_vec_t;
    typedef struct { bit ok; logic [2:0] lo; logic [2:0] hi; logic [2:0] dly; } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0;
    logic [2:0] cur_tap = '0;

    // evaluator model state
    logic [7:0] pass_mask = '0;
    bit         spurious = 1'b0;
    int         hold_tap = -1;
    int         n_evals = 0, eval_base = 0, eval_bad = 0, wait_cnt = 0;

    // monitor state
    logic [2:0] prev_d;
    bit         prev_en, prev_ok = 1'b0;
    int         glitches = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            e = '{0, 3'd0, 3'd0, 3'd0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy && c < 200) begin @(negedge clk); c++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s: got busy=1 after %0d cycles expected idle", name, c);
        end
    endtask

    always @(negedge clk) begin
        eval_done = 1'b0;
        eval_pass = 1'b0;
        if (rst_n && eval_req && int'(delay) != hold_tap) begin
            if (wait_cnt >= 1) begin
                eval_done = 1'b1;
                eval_pass = pass_mask[delay];
                if (delay !== 3'(n_evals - eval_base) || enable !== 1'b1) eval_bad++;
                n_evals++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (rst_n && spurious && busy && !enable) begin
                eval_done = 1'b1;
                eval_pass = 1'b1;
            end
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ok = 1'b0;
        end else begin
            if (prev_ok && prev_en && enable && delay !== prev_d) glitches++;
            prev_d  = delay;
            prev_en = enable;
            prev_ok = 1'b1;
        end
    end

    task automatic manual_apply(input man_vec_t v);
        exp_t e;
        @(negedge clk);
        check("man ready before", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_delay = v.req;
        sb.push_back('{0, 3'd0, 3'd0, v.exp_dly});
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int k = 1; k <= G + S; k++) begin
            check("man enable low", enable, 0);
            check("man delay timing", delay, (k >= G + 1) ? v.exp_dly : cur_tap);
            check("man ready low", cfg_ready, 0);
            @(negedge clk);
        end
        check("man enable back", enable, 1);
        check("man ready back", cfg_ready, 1);
        check("man busy clear", busy, 0);
        pop_exp(e);
        check("man final delay", delay, e.dly);
        cur_tap = v.exp_dly;
    endtask

    task automatic run_sweep(input sw_vec_t v, input bit with_cfg, input logic [2:0] cfg_req);
        exp_t e;
        int   c = 0, ready_bad = 0;
        pass_mask = v.mask;
        spurious  = v.spurious;
        eval_base = n_evals;
        @(negedge clk);
        sweep_start = 1'b1;
        if (with_cfg) begin cfg_valid = 1'b1; cfg_delay = cfg_req; end
        #1;
        check("ready masked by sweep_start", cfg_ready, 0);
        sb.push_back('{v.ok, v.lo, v.hi, v.dly});
        @(negedge clk);
        sweep_start = 1'b0;
        while (!cal_done && c < 400) begin
            if (cfg_ready !== 1'b0) ready_bad++;
            @(negedge clk);
            c++;
        end
        spurious = 1'b0;
        if (!cal_done) begin
            checks++; errors++;
            $display("FAIL sweep timeout: got no cal_done in %0d cycles expected a pulse", c);
            return;
        end
        check("ready low during sweep", ready_bad, 0);
        pop_exp(e);
        check("cal_ok", cal_ok, e.ok);
        check("win_lo", win_lo, e.lo);
        check("win_hi", win_hi, e.hi);
        check("sweep final delay", delay, e.dly);
        check("sweep final enable", enable, 1);
        check("sweep busy clear", busy, 0);
        check("eval count", n_evals - eval_base, N);
        cur_tap = v.dly;
        if (with_cfg) begin
            check("pending cfg ready at end", cfg_ready, 1);
            sb.push_back('{0, 3'd0, 3'd0, cfg_req});
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cal_done single pulse", cal_done, 0);
        check("cal_ok held", cal_ok, e.ok);
        if (with_cfg) begin
            check("pending cfg accepted", busy, 1);
            wait_idle("pending cfg apply");
            pop_exp(e);
            check("pending cfg delay", delay, e.dly);
            cur_tap = cfg_req;
        end
    endtask

    man_vec_t man_tbl[4];
    sw_vec_t  sw_tbl[6];

    initial begin
        int c;
        man_tbl[0] = '{3'd5, 3'd5};
        man_tbl[1] = '{3'd0, 3'd0};
        man_tbl[2] = '{3'd7, 3'd7};
        man_tbl[3] = '{3'd7, 3'd7};
        //            mask          pre   spur ok  lo    hi    dly
        sw_tbl[0] = '{8'b0011_1100, 3'd0, 0,   1,  3'd2, 3'd5, 3'd3};
        sw_tbl[1] = '{8'b1100_0110, 3'd0, 0,   1,  3'd1, 3'd2, 3'd1};
        sw_tbl[2] = '{8'b0000_0000, 3'd6, 1,   0,  3'd0, 3'd0, 3'd6};
        sw_tbl[3] = '{8'b1100_0000, 3'd2, 0,   1,  3'd6, 3'd7, 3'd6};
        sw_tbl[4] = '{8'b1111_1111, 3'd5, 1,   1,  3'd0, 3'd7, 3'd3};
        sw_tbl[5] = '{8'b0000_0001, 3'd4, 0,   1,  3'd0, 3'd0, 3'd0};

        repeat (3) @(negedge clk);
        check("reset delay", delay, 0);
        check("reset enable", enable, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle delay", delay, 0);
        check("idle enable", enable, 1);
        check("idle ready", cfg_ready, 1);
        check("idle busy", busy, 0);
        check("idle cal_ok", cal_ok, 0);
        check("idle eval_req", eval_req, 0);
        check("idle cal_done", cal_done, 0);
        check("idle win_lo", win_lo, 0);
        check("idle win_hi", win_hi, 0);

        for (int i = 0; i < 4; i++) manual_apply(man_tbl[i]);

        for (int i = 0; i < 6; i++) begin
            manual_apply('{sw_tbl[i].pre, sw_tbl[i].pre});
            run_sweep(sw_tbl[i], 1'b0, 3'd0);
        end

        // sweep_start and cfg_valid together: sweep wins, cfg waits until the end
        run_sweep(sw_tbl[0], 1'b1, 3'd2);

        // reset while parked in EVAL at tap 4
        hold_tap  = 4;
        pass_mask = 8'b0011_1100;
        eval_base = n_evals;
        @(negedge clk);
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        c = 0;
        while (!(eval_req && delay == 3'd4) && c < 300) begin @(negedge clk); c++; end
        repeat (2) @(negedge clk);
        check("parked in eval at tap 4", {eval_req, delay}, {1'b1, 3'd4});
        rst_n = 1'b0;
        #1;
        check("async reset delay", delay, 0);
        check("async reset enable", enable, 1);
        check("async reset busy", busy, 0);
        check("async reset eval_req", eval_req, 0);
        check("async reset cal_ok", cal_ok, 0);
        check("async reset win_hi", win_hi, 0);
        repeat (2) @(negedge clk);
        hold_tap = -1;
        rst_n    = 1'b1;
        cur_tap  = 3'd0;
        repeat (3) @(negedge clk);
        check("post reset idle", busy, 0);
        check("post reset no cal_done", cal_done, 0);
        manual_apply('{3'd3, 3'd3});

        check("delay stable while enabled", glitches, 0);
        check("eval tap order and enable", eval_bad, 0);
        check("scoreboard drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish by %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_delay_ctrl.md
Name: clk_delay_ctrl

Overview:
Sequencing and calibration controller for the serial-link `configurable_delay` tap line. It applies new tap settings glitch-safely: gate the delayed clock, change the tap, let it settle, then ungate. It can also run an automatic tap sweep: each tap is scored by an external link-level pass/fail evaluator, and the controller programs the centre of the first passing window. It sits in the link PHY clocking path, between the config register file and `configurable_delay`.

Parameters:
NUM_STEPS, 8, number of delay taps; power of 2, ≥2; DelW = $clog2(NUM_STEPS)
DEFAULT_DELAY, 0, tap driven out of reset; must be < NUM_STEPS
GATE_CYCLES, 4, cycles enable_o is held low before a tap change; ≥1
SETTLE_CYCLES, 16, cycles after a tap change before enable_o reasserts; ≥1

Ports:
clk_i  in  1  controller clock; sole clock domain
rst_ni  in  1  asynchronous active-low reset
cfg_valid_i  in  1  manual tap request valid
cfg_ready_o  out  1  manual tap request ready
cfg_delay_i  in  DelW  requested tap
sweep_start_i  in  1  single-cycle pulse that starts calibration
eval_req_o  out  1  level; asks evaluator to test the current tap
eval_done_i  in  1  single-cycle evaluator result strobe
eval_pass_i  in  1  evaluator verdict; valid with eval_done_i
delay_o  out  DelW  to configurable_delay delay_i
enable_o  out  1  to configurable_delay enable_i
busy_o  out  1  high in every state except IDLE
cal_done_o  out  1  one-cycle pulse at sweep completion
cal_ok_o  out  1  result of the last sweep; held
win_lo_o  out  DelW  first passing tap of the last sweep; held
win_hi_o  out  DelW  last passing tap of the last sweep; held

Behaviour:
- Reset values: delay_o=DEFAULT_DELAY, enable_o=1, state IDLE, eval_req_o=0, cal_done_o=0, cal_ok_o=0, win_lo_o=0, win_hi_o=0, cfg_ready_o=1.
- States: IDLE, GATE, UPDATE, SETTLE, EVAL, DONE. One shared cycle counter is sized for max(GATE_CYCLES, SETTLE_CYCLES).
- cfg_ready_o = (state==IDLE) && !sweep_start_i. sweep_start_i has priority over cfg; a simultaneous cfg is not accepted.
- Manual apply: a handshake at cycle t gives the following sequence.
  - Cycles t+1 .. t+GATE_CYCLES: GATE, enable_o=0.
  - Cycle t+GATE_CYCLES+1: UPDATE; delay_o takes the new tap this cycle; enable_o stays 0.
  - SETTLE_CYCLES-1 further SETTLE cycles follow, enable_o=0.
  - Cycle t+1+GATE_CYCLES+SETTLE_CYCLES: enable_o=1, state IDLE, cfg_ready_o=1.
  - Delay changes only while enable_o=0.
  - Requesting the current tap still runs the full sequence.
- Sweep, entered from IDLE on sweep_start_i:
  - Latch the pre-sweep tap, clear the window trackers, set tap index=0.
  - For each tap: GATE → UPDATE (delay_o=index) → SETTLE → EVAL.
  - In EVAL: enable_o=1 and eval_req_o=1 until eval_done_i. eval_req_o drops in the cycle after eval_done_i.
  - Window tracking:
    - First pass: record lo=hi=index.
    - Pass contiguous with the window: hi=index.
    - Fail after a window has opened: close the window; later passes are ignored.
  - Index NUM_STEPS-1 evaluated → DONE.
- DONE:
  - If a window exists: cal_ok_o=1, win_lo_o=lo, win_hi_o=hi, target=(lo+hi)>>1. Compute the sum in DelW+1 bits; floor rounding.
  - If no window: cal_ok_o=0, window outputs=0, target=pre-sweep tap.
  - Target is applied via GATE/UPDATE/SETTLE, then IDLE.
  - cal_done_o pulses for exactly one cycle on the IDLE-entry cycle. cal_* and win_* outputs update on that same cycle.
- Ignored inputs:
  - eval_done_i outside EVAL.
  - sweep_start_i while busy.
  - cfg_valid_i while busy; it stays pending, ready=0.
- Async reset mid-sequence: immediately return to reset values, including enable_o=1 and delay_o=DEFAULT_DELAY. Partial sweep results are discarded.
- Index arithmetic: the loop terminates on index==NUM_STEPS-1 and never relies on counter wrap.

Test Plan:
All scenarios use NUM_STEPS=8, GATE_CYCLES=2, SETTLE_CYCLES=4, DEFAULT_DELAY=0.
- Reset/idle: hold rst_ni=0, then release. Expect delay_o=0, enable_o=1, cfg_ready_o=1, busy_o=0, cal_ok_o=0.
- Manual apply: cfg handshake delay=5 at t. Expect:
  - enable_o=0 during t+1..t+6.
  - delay_o changes to 5 exactly at t+3.
  - enable_o=1 and cfg_ready_o=1 at t+7.
  - An assertion checks delay_o never changes while enable_o=1.
- Sweep with pass pattern taps 2,3,4,5 (others fail). Expect 8 eval_req_o cycles-of-handshake, then cal_done_o pulse, cal_ok_o=1, win_lo_o=2, win_hi_o=5, final delay_o=3 with enable_o=1.
- Split windows, pass on taps 1,2,6,7. Expect win_lo_o=1, win_hi_o=2, delay_o=1.
- All fail, with delay set to 6 beforehand. Expect cal_ok_o=0, win_lo_o=0, win_hi_o=0, delay_o restored to 6.
- Collisions and reset:
  - sweep_start_i and cfg_valid_i together in IDLE: sweep runs, cfg_ready_o=0 until the sweep ends.
  - Spurious eval_done_i during SETTLE is ignored.
  - rst_ni pulse while in EVAL at tap 4: delay_o=0, enable_o=1, busy_o=0 asynchronously.
